// File: rtl/lock_seq_ctrl.sv
// lock_seq_ctrl: sequencing controller for the keypad combination lock.
// Handles code entry, open/relock, reprogramming and failed-attempt lockout.
// Optional build macro AUTO_RELOCK_EN adds an OPEN idle timeout.
// Ports: clk, rst (async, active-high), key_valid/key_code (key events),
//        state, digit_idx, seq, open, alarm, lockout, fails, prog_done.
module lock_seq_ctrl #(
    parameter logic [31:0] RESET_SEQ      = 32'h12345678,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 500,
    parameter int unsigned RELOCK_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic [3:0]  state,
    output logic [2:0]  digit_idx,
    output logic [31:0] seq,
    output logic        open,
    output logic        alarm,
    output logic        lockout,
    output logic [2:0]  fails,
    output logic        prog_done
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ENTRY   = 4'd1,
        S_OPEN    = 4'd2,
        S_PROG    = 4'd3,
        S_ALARM   = 4'd4,
        S_LOCKOUT = 4'd5
    } state_e;

    // One timer width shared by the lockout and relock counters.
    localparam int unsigned CMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ?
                                   LOCKOUT_CYCLES : RELOCK_CYCLES;
    localparam int unsigned TW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]    MAXF      = 3'(MAX_FAILS);

    state_e         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [31:0]    seq_q, seq_d;
    logic [2:0]     fails_q, fails_d;
    logic           mism_q, mism_d;
    logic [27:0]    shadow_q, shadow_d;
    logic [TW-1:0]  lock_tmr_q, lock_tmr_d;
    logic           pd_q, pd_d;
    logic           open_q, alarm_q, lockout_q;

    logic           is_digit, is_clr, is_prog, is_lock, key_acc;
    logic [4:0]     nib_hi;
    logic [3:0]     nib;
    logic           mism_new;
    logic [2:0]     fails_inc;

`ifdef AUTO_RELOCK_EN
    localparam logic [TW-1:0] RELOCK_LOAD = TW'(RELOCK_CYCLES - 1);
    logic [TW-1:0]  relock_q, relock_d;
`endif

    assign is_digit = key_valid && !key_code[4];
    assign is_clr   = key_valid && (key_code == 5'd16);
    assign is_prog  = key_valid && (key_code == 5'd17);
    assign is_lock  = key_valid && (key_code == 5'd18);
    assign key_acc  = key_valid && (key_code <= 5'd18);

    // Nibble for digit i sits at bits 31-4i down; {~i,2'b11} == 31-4i.
    assign nib_hi    = {~idx_q, 2'b11};
    assign nib       = seq_q[nib_hi -: 4];
    assign mism_new  = mism_q | (key_code[3:0] != nib);
    assign fails_inc = (fails_q >= MAXF) ? MAXF : fails_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        fails_d    = fails_q;
        mism_d     = mism_q;
        shadow_d   = shadow_q;
        lock_tmr_d = lock_tmr_q;
        pd_d       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (is_clr) begin
                    state_d = S_ENTRY;
                    idx_d   = 3'd0;
                    mism_d  = 1'b0;
                end
            end
            S_ENTRY: begin
                if (is_clr) begin
                    idx_d  = 3'd0;
                    mism_d = 1'b0;
                end else if (is_digit) begin
                    if (idx_q == 3'd7) begin
                        idx_d  = 3'd0;
                        mism_d = 1'b0;
                        if (!mism_new) begin
                            state_d = S_OPEN;
                            fails_d = 3'd0;
                        end else begin
                            fails_d = fails_inc;
                            if (fails_inc == MAXF) begin
                                state_d    = S_LOCKOUT;
                                lock_tmr_d = LOCK_LOAD;
                            end else begin
                                state_d = S_ALARM;
                            end
                        end
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        mism_d = mism_new;
                    end
                end
            end
            S_ALARM: begin
                if (is_clr) begin
                    state_d = S_ENTRY;
                    idx_d   = 3'd0;
                    mism_d  = 1'b0;
                end
            end
            S_LOCKOUT: begin
                if (lock_tmr_q == '0) begin
                    state_d = S_IDLE;
                    fails_d = 3'd0;
                end else begin
                    lock_tmr_d = lock_tmr_q - 1'b1;
                end
            end
            S_OPEN: begin
                if (is_lock) begin
                    state_d = S_IDLE;
                end else if (is_prog) begin
                    state_d  = S_PROG;
                    idx_d    = 3'd0;
                    shadow_d = '0;
                end
`ifdef AUTO_RELOCK_EN
                else if (!key_acc && relock_q == '0) begin
                    state_d = S_IDLE;
                end
`endif
            end
            S_PROG: begin
                if (is_clr) begin
                    state_d = S_OPEN;
                    idx_d   = 3'd0;
                end else if (is_digit) begin
                    if (idx_q == 3'd7) begin
                        seq_d   = {shadow_q, key_code[3:0]};
                        pd_d    = 1'b1;
                        state_d = S_OPEN;
                        idx_d   = 3'd0;
                    end else begin
                        shadow_d = {shadow_q[23:0], key_code[3:0]};
                        idx_d    = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef AUTO_RELOCK_EN
    // Reload on arrival in OPEN or any accepted key there; held in PROG.
    always_comb begin
        relock_d = relock_q;
        if (state_d == S_OPEN && (state_q != S_OPEN || key_acc))
            relock_d = RELOCK_LOAD;
        else if (state_q == S_OPEN && relock_q != '0)
            relock_d = relock_q - 1'b1;
    end
`else
    logic unused_acc;
    assign unused_acc = key_acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            seq_q      <= RESET_SEQ;
            fails_q    <= 3'd0;
            mism_q     <= 1'b0;
            shadow_q   <= '0;
            lock_tmr_q <= '0;
            pd_q       <= 1'b0;
            open_q     <= 1'b0;
            alarm_q    <= 1'b0;
            lockout_q  <= 1'b0;
`ifdef AUTO_RELOCK_EN
            relock_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            fails_q    <= fails_d;
            mism_q     <= mism_d;
            shadow_q   <= shadow_d;
            lock_tmr_q <= lock_tmr_d;
            pd_q       <= pd_d;
            open_q     <= (state_d == S_OPEN) || (state_d == S_PROG);
            alarm_q    <= (state_d == S_ALARM) || (state_d == S_LOCKOUT);
            lockout_q  <= (state_d == S_LOCKOUT);
`ifdef AUTO_RELOCK_EN
            relock_q   <= relock_d;
`endif
        end
    end

    assign state     = state_q;
    assign digit_idx = idx_q;
    assign seq       = seq_q;
    assign fails     = fails_q;
    assign open      = open_q;
    assign alarm     = alarm_q;
    assign lockout   = lockout_q;
    assign prog_done = pd_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// tb_lock_seq_ctrl: self-checking bench for lock_seq_ctrl.
// Directed scenarios plus random keys against a queue-based lock model.
module tb_lock_seq_ctrl;

    localparam int LOCK_CYC = 500;
    localparam int RELOCK   = 20;
    localparam int MAXF     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [3:0]  state;
    logic [2:0]  digit_idx;
    logic [31:0] seq;
    logic        open, alarm, lockout, prog_done;
    logic [2:0]  fails;

    int n_checks = 0;
    int n_fail   = 0;

    lock_seq_ctrl #(
        .RESET_SEQ(32'h12345678),
        .MAX_FAILS(MAXF),
        .LOCKOUT_CYCLES(LOCK_CYC),
        .RELOCK_CYCLES(RELOCK)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .state(state), .digit_idx(digit_idx), .seq(seq), .open(open),
        .alarm(alarm), .lockout(lockout), .fails(fails),
        .prog_done(prog_done)
    );

    always #5 clk = ~clk;

    // Reference model: 0 IDLE,1 ENTRY,2 OPEN,3 PROG,4 ALARM,5 LOCKOUT
    int         ms;
    logic [3:0] mcomb[8];
    logic [3:0] ment[$];
    logic [3:0] mnew[$];
    int         mfails;
    int         mlock_left;
    int         mrelock_left;
    bit         mpd;

    task automatic model_reset();
        logic [31:0] r;
        r = 32'h12345678;
        for (int i = 0; i < 8; i++) mcomb[i] = r[31-4*i -: 4];
        ms = 0; ment.delete(); mnew.delete();
        mfails = 0; mlock_left = 0; mrelock_left = 0; mpd = 0;
    endtask

    function automatic logic [31:0] mseq();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[27:0], mcomb[i]};
        return v;
    endfunction

    function automatic int midx();
        if (ms == 1) return ment.size();
        if (ms == 3) return mnew.size();
        return 0;
    endfunction

    task automatic model_step(input logic v, input logic [4:0] c);
        bit acc, dig, ok;
        acc = v && (c <= 18);
        dig = v && (c < 16);
        mpd = 0;
        case (ms)
            0: if (acc && c == 16) begin ms = 1; ment.delete(); end
            1: begin
                if (acc && c == 16) ment.delete();
                else if (dig) begin
                    ment.push_back(c[3:0]);
                    if (ment.size() == 8) begin
                        ok = 1;
                        for (int i = 0; i < 8; i++)
                            if (ment[i] != mcomb[i]) ok = 0;
                        ment.delete();
                        if (ok) begin
                            ms = 2; mfails = 0; mrelock_left = RELOCK;
                        end else begin
                            if (mfails < MAXF) mfails++;
                            if (mfails == MAXF) begin
                                ms = 5; mlock_left = LOCK_CYC;
                            end else ms = 4;
                        end
                    end
                end
            end
            4: if (acc && c == 16) begin ms = 1; ment.delete(); end
            5: begin
                mlock_left--;
                if (mlock_left == 0) begin ms = 0; mfails = 0; end
            end
            2: begin
                if (acc && c == 18) ms = 0;
                else if (acc && c == 17) begin ms = 3; mnew.delete(); end
                else if (acc) mrelock_left = RELOCK;
                else begin
`ifdef AUTO_RELOCK_EN
                    mrelock_left--;
                    if (mrelock_left == 0) ms = 0;
`endif
                end
            end
            3: begin
                if (acc && c == 16) begin
                    ms = 2; mnew.delete(); mrelock_left = RELOCK;
                end else if (dig) begin
                    mnew.push_back(c[3:0]);
                    if (mnew.size() == 8) begin
                        for (int i = 0; i < 8; i++) mcomb[i] = mnew[i];
                        mnew.delete(); mpd = 1; ms = 2;
                        mrelock_left = RELOCK;
                    end
                end
            end
            default: ms = 0;
        endcase
    endtask

    task automatic tick(input logic v, input logic [4:0] c);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        model_step(v, c);
        #1;
        key_valid = 1'b0;
        key_code  = 5'd0;
    endtask

    task automatic enter(input logic [31:0] code);
        tick(1'b1, 5'd16);
        for (int i = 0; i < 8; i++) tick(1'b1, {1'b0, code[31-4*i -: 4]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (state !== 4'd0) begin n_fail++;
            $display("FAIL rst_state: got %0d expected 0", state); end
        n_checks++;
        if (digit_idx !== 3'd0 || fails !== 3'd0) begin n_fail++;
            $display("FAIL rst_cnt: got idx %0d fails %0d expected 0 0", digit_idx, fails); end
        n_checks++;
        if (seq !== 32'h12345678) begin n_fail++;
            $display("FAIL rst_seq: got %h expected 12345678", seq); end
        n_checks++;
        if ({open, alarm, lockout, prog_done} !== 4'b0000) begin n_fail++;
            $display("FAIL rst_flags: got %b expected 0000", {open, alarm, lockout, prog_done}); end
    endtask

    task automatic test_open();
        tick(1'b1, 5'd16);
        for (int d = 1; d <= 7; d++) tick(1'b1, 5'(d));
        n_checks++;
        if (state !== 4'd1 || digit_idx !== 3'd7) begin n_fail++;
            $display("FAIL open_pre: got st %0d idx %0d expected 1 7", state, digit_idx); end
        tick(1'b1, 5'd8);
        n_checks++;
        if (state !== 4'd2 || open !== 1'b1 || fails !== 3'd0) begin n_fail++;
            $display("FAIL open_ok: got st %0d open %b fails %0d expected 2 1 0", state, open, fails); end
        n_checks++;
        if (digit_idx !== 3'd0) begin n_fail++;
            $display("FAIL open_idx: got %0d expected 0", digit_idx); end
        tick(1'b1, 5'd18);
        n_checks++;
        if (state !== 4'd0 || open !== 1'b0) begin n_fail++;
            $display("FAIL relock_key: got st %0d open %b expected 0 0", state, open); end
    endtask

    task automatic test_alarm();
        tick(1'b1, 5'd16);
        tick(1'b1, 5'd9);
        n_checks++;
        if (state !== 4'd1 || digit_idx !== 3'd1) begin n_fail++;
            $display("FAIL alarm_noreject: got st %0d idx %0d expected 1 1", state, digit_idx); end
        for (int d = 2; d <= 8; d++) tick(1'b1, 5'(d));
        n_checks++;
        if (state !== 4'd4 || alarm !== 1'b1 || fails !== 3'd1) begin n_fail++;
            $display("FAIL alarm_state: got st %0d alarm %b fails %0d expected 4 1 1", state, alarm, fails); end
    endtask

    task automatic test_lockout();
        do_reset();
        enter(32'h0);
        enter(32'h0);
        n_checks++;
        if (state !== 4'd4 || fails !== 3'd2) begin n_fail++;
            $display("FAIL lock_two: got st %0d fails %0d expected 4 2", state, fails); end
        enter(32'h0);
        n_checks++;
        if (state !== 4'd5 || lockout !== 1'b1 || alarm !== 1'b1) begin n_fail++;
            $display("FAIL lock_enter: got st %0d lockout %b alarm %b expected 5 1 1", state, lockout, alarm); end
        for (int k = 1; k < LOCK_CYC; k++) begin
            if (k % 7 == 0) tick(1'b1, 5'($urandom_range(0, 18)));
            else tick(1'b0, 5'd0);
        end
        n_checks++;
        if (state !== 4'd5 || fails !== 3'd3) begin n_fail++;
            $display("FAIL lock_hold: got st %0d fails %0d expected 5 3", state, fails); end
        tick(1'b0, 5'd0);
        n_checks++;
        if (state !== 4'd0 || fails !== 3'd0 || alarm !== 1'b0) begin n_fail++;
            $display("FAIL lock_exit: got st %0d fails %0d alarm %b expected 0 0 0", state, fails, alarm); end
    endtask

    task automatic test_prog();
        logic [31:0] nc;
        nc = 32'hABCD0123;
        enter(32'h12345678);
        tick(1'b1, 5'd17);
        n_checks++;
        if (state !== 4'd3 || open !== 1'b1) begin n_fail++;
            $display("FAIL prog_enter: got st %0d open %b expected 3 1", state, open); end
        for (int i = 0; i < 7; i++) tick(1'b1, {1'b0, nc[31-4*i -: 4]});
        n_checks++;
        if (prog_done !== 1'b0 || seq !== 32'h12345678) begin n_fail++;
            $display("FAIL prog_partial: got pd %b seq %h expected 0 12345678", prog_done, seq); end
        tick(1'b1, 5'd3);
        n_checks++;
        if (prog_done !== 1'b1 || seq !== 32'hABCD0123 || state !== 4'd2) begin n_fail++;
            $display("FAIL prog_commit: got pd %b seq %h st %0d expected 1 abcd0123 2", prog_done, seq, state); end
        tick(1'b0, 5'd0);
        n_checks++;
        if (prog_done !== 1'b0) begin n_fail++;
            $display("FAIL prog_pulse: got %b expected 0", prog_done); end
        tick(1'b1, 5'd18);
        enter(nc);
        n_checks++;
        if (state !== 4'd2) begin n_fail++;
            $display("FAIL prog_newcode: got st %0d expected 2", state); end
        tick(1'b1, 5'd18);
        enter(32'h12345678);
        n_checks++;
        if (state !== 4'd4 || fails !== 3'd1) begin n_fail++;
            $display("FAIL prog_oldcode: got st %0d fails %0d expected 4 1", state, fails); end
    endtask

    task automatic test_prog_abort();
        enter(32'hABCD0123);
        tick(1'b1, 5'd17);
        for (int i = 0; i < 3; i++) tick(1'b1, 5'd5);
        n_checks++;
        if (digit_idx !== 3'd3 || state !== 4'd3) begin n_fail++;
            $display("FAIL abort_pre: got idx %0d st %0d expected 3 3", digit_idx, state); end
        tick(1'b1, 5'd16);
        n_checks++;
        if (state !== 4'd2 || seq !== 32'hABCD0123 || digit_idx !== 3'd0) begin n_fail++;
            $display("FAIL abort: got st %0d seq %h idx %0d expected 2 abcd0123 0", state, seq, digit_idx); end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 5'd18);
        tick(1'b1, 5'd16);
        for (int i = 0; i < 5; i++) tick(1'b1, 5'd10);
        n_checks++;
        if (state !== 4'd1 || digit_idx !== 3'd5) begin n_fail++;
            $display("FAIL mid_pre: got st %0d idx %0d expected 1 5", state, digit_idx); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'd0 || digit_idx !== 3'd0 || seq !== 32'h12345678 ||
            fails !== 3'd0 || {open, alarm, lockout, prog_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_rst: got st %0d idx %0d seq %h fails %0d expected 0 0 12345678 0",
                     state, digit_idx, seq, fails);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_relock();
        do_reset();
        enter(32'h12345678);
`ifdef AUTO_RELOCK_EN
        repeat (RELOCK - 1) tick(1'b0, 5'd0);
        n_checks++;
        if (state !== 4'd2) begin n_fail++;
            $display("FAIL relock_hold: got st %0d expected 2", state); end
        tick(1'b0, 5'd0);
        n_checks++;
        if (state !== 4'd0) begin n_fail++;
            $display("FAIL relock_fire: got st %0d expected 0", state); end
        enter(32'h12345678);
        repeat (9) tick(1'b0, 5'd0);
        tick(1'b1, 5'd5);
        repeat (RELOCK - 1) tick(1'b0, 5'd0);
        n_checks++;
        if (state !== 4'd2) begin n_fail++;
            $display("FAIL relock_ext_hold: got st %0d expected 2", state); end
        tick(1'b0, 5'd0);
        n_checks++;
        if (state !== 4'd0) begin n_fail++;
            $display("FAIL relock_ext_fire: got st %0d expected 0", state); end
`else
        repeat (3 * RELOCK) tick(1'b0, 5'd0);
        n_checks++;
        if (state !== 4'd2 || open !== 1'b1) begin n_fail++;
            $display("FAIL open_persist: got st %0d open %b expected 2 1", state, open); end
        tick(1'b1, 5'd18);
`endif
    endtask

    task automatic test_random();
        logic [4:0] plan[$];
        logic       v;
        logic [4:0] c;
        int         r;
        do_reset();
        for (int step = 0; step < 1500; step++) begin
            if (plan.size() == 0) begin
                r = $urandom_range(0, 99);
                if ((ms == 0 || ms == 4) && r < 10) begin
                    plan.push_back(5'd16);
                    for (int i = 0; i < 8; i++) plan.push_back({1'b0, mcomb[i]});
                end else if (ms == 2 && r < 8) begin
                    plan.push_back(5'd17);
                    for (int i = 0; i < 8; i++) plan.push_back(5'($urandom_range(0, 15)));
                end
            end
            if (plan.size() != 0) begin
                v = 1'b1;
                c = plan.pop_front();
            end else begin
                r = $urandom_range(0, 99);
                v = (r >= 35);
                c = (r < 80) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(16, 31));
            end
            tick(v, c);
            n_checks++;
            if (state !== 4'(ms)) begin n_fail++;
                $display("FAIL rnd_state@%0d: got %0d expected %0d", step, state, ms); end
            n_checks++;
            if (digit_idx !== 3'(midx())) begin n_fail++;
                $display("FAIL rnd_idx@%0d: got %0d expected %0d", step, digit_idx, midx()); end
            n_checks++;
            if (seq !== mseq() || fails !== 3'(mfails)) begin n_fail++;
                $display("FAIL rnd_seq@%0d: got %h/%0d expected %h/%0d", step, seq, fails, mseq(), mfails); end
            n_checks++;
            if ({open, alarm, lockout, prog_done} !==
                {(ms == 2 || ms == 3), (ms == 4 || ms == 5), (ms == 5), mpd}) begin
                n_fail++;
                $display("FAIL rnd_flags@%0d: got %b for state %0d pd %b", step,
                         {open, alarm, lockout, prog_done}, ms, mpd);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 5'd0;
        model_reset();
        #3;
        test_reset();
        test_open();
        test_alarm();
        test_lockout();
        test_prog();
        test_prog_abort();
        test_reset_mid();
        test_relock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
